fifo_sync_param: RTL and testbench
==================================

// Module: fifo_sync_param
// PURPOSE
//  Parametrised single-clock FIFO; successor to the fixed 8-bit x 256 FIFO.
//  Generic width and depth, occupancy count, programmable almost-full/empty
//  thresholds, Valid strobe on read data, sticky overflow/underflow error flags.
//  Sits between producer and consumer blocks in one clock domain.
// PARAMETERS
//  DATA_W   8    data word width in bits
//  DEPTH    256  number of entries; power of two, >= 4
//  ADDR_W   8    log2(DEPTH); must match DEPTH (checked at elaboration)
//  AF_LVL   DEPTH-4  Almost_Full asserted when Count >= AF_LVL
//  AE_LVL   4    Almost_Empty asserted when Count <= AE_LVL
// PORTS
//  CLK          in   1         clock, rising edge
//  RST          in   1         synchronous, active-high reset
//  Din          in   DATA_W    write data
//  WR_EN        in   1         write request
//  RD_EN        in   1         read request
//  Dout         out  DATA_W    read data, registered
//  Valid        out  1         Dout holds a word popped on previous cycle
//  Empty        out  1         Count == 0
//  Full         out  1         Count == DEPTH
//  Almost_Empty out  1         Count <= AE_LVL
//  Almost_Full  out  1         Count >= AF_LVL
//  Count        out  ADDR_W+1  current occupancy, 0..DEPTH
//  Overflow     out  1         sticky: write attempted while Full
//  Underflow    out  1         sticky: read attempted while Empty
//  Err_Clr      in   1         clears Overflow/Underflow next edge
// BEHAVIOUR
//  - Reset: wr/rd pointers=0, Count=0, Dout=0, Valid=0, Empty=1, Full=0,
//    Almost_Empty=1, Almost_Full=0, Overflow=0, Underflow=0. Memory not cleared.
//  - RST has priority over all inputs; RST mid-stream discards all contents.
//  - Pointers ADDR_W+1 bits; low ADDR_W bits address memory; MSB is wrap bit.
//    Full when low bits equal and MSBs differ; Empty when pointers equal.
//  - Write accepted iff WR_EN && !Full (flags sampled before the edge):
//    mem[wr_ptr]<=Din, wr_ptr+1.
//  - Read accepted iff RD_EN && !Empty: Dout<=mem[rd_ptr], rd_ptr+1, Valid<=1
//    next cycle. Read latency 1 cycle. No accepted read -> Valid<=0, Dout holds.
//  - Simultaneous WR&RD when neither Full nor Empty: both accepted, Count unchanged.
//  - WR&RD while Full: read accepted, write rejected, Overflow set.
//  - WR&RD while Empty: write accepted, read rejected, Underflow set;
//    no write-through bypass.
//  - Count: +1 on write-only, -1 on read-only, unchanged otherwise; never
//    exceeds DEPTH or drops below 0. All status flags are registered and
//    consistent with Count in the same cycle.
//  - Rejected requests do not change pointers, Count or memory.
//  - Overflow/Underflow sticky until Err_Clr or RST; if Err_Clr and a new error
//    occur on the same edge, flag stays set.
//  - Pointer wrap from DEPTH-1 to 0 toggles MSB; data order is preserved.
// TESTING
//  1 RST=1 two cycles -> Empty=1, Count=0, Valid=0, Dout=0, error flags 0.
//  2 DEPTH=256: write 0x00..0xFF -> Full=1, Count=256, Almost_Full from Count=252;
//    read all -> Dout 0x00..0xFF in order, Valid each cycle after RD_EN, Empty=1.
//  3 Full + WR_EN with Din=0xAA -> Overflow=1, Count=256, 0xAA never read out;
//    Err_Clr=1 -> Overflow=0.
//  4 Empty + RD_EN -> Underflow=1, Valid=0, Dout unchanged; WR&RD on Empty -> Count=1.
//  5 Count=100, WR&RD 300 cycles with incrementing data -> Count stays 100, pointers
//    wrap, output sequence matches scoreboard.
//  6 Write 10 words, RST=1 mid-stream with WR_EN=1 -> Count=0, Empty=1; next read
//    returns only post-reset data.

Source files
------------

// File: rtl/fifo_sync_param_if.sv
// Write/read/status bundle for fifo_sync_param; master is the producer/consumer side.
interface fifo_sync_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic [DATA_W-1:0] din;
  logic              wr_en;
  logic              rd_en;
  logic              err_clr;
  logic [DATA_W-1:0] dout;
  logic              valid;
  logic              empty;
  logic              full;
  logic              almost_empty;
  logic              almost_full;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output din, wr_en, rd_en, err_clr,
    input  dout, valid, empty, full, almost_empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  din, wr_en, rd_en, err_clr,
    output dout, valid, empty, full, almost_empty, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with registered status, occupancy and sticky error flags.
// Read data one cycle after an accepted read; writes when full / reads when empty are dropped and flagged.
module fifo_sync_param #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int AF_LVL = DEPTH - 4,
  parameter int AE_LVL = 4
) (
  input logic              clk,
  input logic              rst,
  fifo_sync_param_if.slave bus
);

  if (ADDR_W != $clog2(DEPTH) || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("fifo_sync_param: DEPTH must be a power of two >= 4 and ADDR_W = log2(DEPTH)");
  end

  localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] AF_C = (ADDR_W+1)'(AF_LVL);
  localparam logic [ADDR_W:0] AE_C = (ADDR_W+1)'(AE_LVL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr, rd_ptr, count_q;
  logic [ADDR_W:0]   wr_ptr_nxt, rd_ptr_nxt, count_nxt;
  logic [DATA_W-1:0] dout_q;
  logic              valid_q, empty_q, full_q, ae_q, af_q, ovf_q, unf_q;
  logic              full_nxt, empty_nxt, ae_nxt, af_nxt, ovf_nxt, unf_nxt;
  logic              wr_acc, rd_acc;

  // Acceptance uses the registered flags, i.e. the state before this edge.
  assign wr_acc = bus.wr_en & ~full_q;
  assign rd_acc = bus.rd_en & ~empty_q;

  always_comb begin
    wr_ptr_nxt = wr_acc ? wr_ptr + ONE : wr_ptr;
    rd_ptr_nxt = rd_acc ? rd_ptr + ONE : rd_ptr;
    count_nxt  = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count_q + ONE;
      2'b01:   count_nxt = count_q - ONE;
      default: count_nxt = count_q;
    endcase
    full_nxt  = (wr_ptr_nxt[ADDR_W-1:0] == rd_ptr_nxt[ADDR_W-1:0]) &&
                (wr_ptr_nxt[ADDR_W] != rd_ptr_nxt[ADDR_W]);
    empty_nxt = (wr_ptr_nxt == rd_ptr_nxt);
    ae_nxt    = (count_nxt <= AE_C);
    af_nxt    = (count_nxt >= AF_C);
    // A fresh error on the clearing edge wins over the clear.
    ovf_nxt   = (ovf_q & ~bus.err_clr) | (bus.wr_en & full_q);
    unf_nxt   = (unf_q & ~bus.err_clr) | (bus.rd_en & empty_q);
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr[ADDR_W-1:0]] <= bus.din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ae_q    <= 1'b1;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      count_q <= count_nxt;
      valid_q <= rd_acc;
      if (rd_acc) begin
        dout_q <= mem[rd_ptr[ADDR_W-1:0]];
      end
      empty_q <= empty_nxt;
      full_q  <= full_nxt;
      ae_q    <= ae_nxt;
      af_q    <= af_nxt;
      ovf_q   <= ovf_nxt;
      unf_q   <= unf_nxt;
    end
  end

  assign bus.dout         = dout_q;
  assign bus.valid        = valid_q;
  assign bus.empty        = empty_q;
  assign bus.full         = full_q;
  assign bus.almost_empty = ae_q;
  assign bus.almost_full  = af_q;
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: reference queue model, scoreboard for read data, per-cycle status checks.
module tb_fifo_sync_param;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;
  localparam int AF_LVL = 252;
  localparam int AE_LVL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fifo_sync_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  fifo_sync_param #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .AF_LVL(AF_LVL), .AE_LVL(AE_LVL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  logic       movf, munf, mvalid;
  logic [7:0] mdout;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Read-data monitor: every Valid word must be the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst && bus.valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got %0h want none", bus.dout);
      end else begin
        e = exp_q.pop_front();
        check("sb_dout", bus.dout, e);
      end
    end
  end

  task automatic check_state();
    check("count",  bus.count,        mq.size());
    check("empty",  bus.empty,        mq.size() == 0);
    check("full",   bus.full,         mq.size() == DEPTH);
    check("a_emp",  bus.almost_empty, mq.size() <= AE_LVL);
    check("a_full", bus.almost_full,  mq.size() >= AF_LVL);
    check("ovf",    bus.overflow,     movf);
    check("unf",    bus.underflow,    munf);
    check("valid",  bus.valid,        mvalid);
    check("dout",   bus.dout,         mdout);
  endtask

  // Called on a falling edge; applies one cycle of stimulus and checks the result.
  task automatic step(input logic w, input logic r, input logic [7:0] d, input logic ec);
    bit mfull, mempty;
    mfull  = (mq.size() == DEPTH);
    mempty = (mq.size() == 0);
    bus.din     = d;
    bus.wr_en   = w;
    bus.rd_en   = r;
    bus.err_clr = ec;
    mvalid = r && !mempty;
    if (mvalid) begin
      mdout = mq.pop_front();
      exp_q.push_back(mdout);
    end
    if (w && !mfull) mq.push_back(d);
    movf = (movf && !ec) || (w && mfull);
    munf = (munf && !ec) || (r && mempty);
    @(posedge clk);
    @(negedge clk);
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.err_clr = 1'b0;
    check_state();
  endtask

  task automatic do_reset(input int n, input logic w);
    rst         = 1'b1;
    bus.wr_en   = w;
    bus.din     = 8'hEE;
    bus.rd_en   = 1'b0;
    bus.err_clr = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    bus.wr_en = 1'b0;
    mq.delete();
    exp_q.delete();
    movf   = 1'b0;
    munf   = 1'b0;
    mvalid = 1'b0;
    mdout  = 8'h00;
    check_state();
  endtask

  initial begin
    bus.din     = '0;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.err_clr = 1'b0;

    // Reset state
    do_reset(2, 1'b0);

    // Fill 0x00..0xFF, then drain in order
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(i), 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // Overflow: write while full, error on the clearing edge, WR&RD while full
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(i) ^ 8'h55, 1'b0);
    step(1'b1, 1'b0, 8'hAA, 1'b0);
    step(1'b1, 1'b0, 8'hAA, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b1, 8'hAA, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

    // Underflow: read while empty holds Dout, WR&RD on empty writes only
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'h33, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b1, 8'h00, 1'b0);

    // Steady occupancy 100 with simultaneous WR&RD, pointers wrap
    for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 8'(i), 1'b0);
    for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 8'(100 + i), 1'b0);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

    // Reset mid-stream with WR_EN held high discards everything
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'h80 + 8'(i), 1'b0);
    do_reset(1, 1'b1);
    step(1'b1, 1'b0, 8'hC3, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    step(1'b0, 1'b0, 8'h00, 1'b0);
    check("sb_left", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
